bpf_switch_seq: RTL and testbench
=================================

# bpf_switch_seq

Sequences band-pass-filter switching downstream of the frequency-to-band decoder. Takes the 3-bit BPF select code and qualifies it for stability. Drives the filter switch lines break-before-make, muting the signal path around each change. Sits between the band decoder and the BPF switch pins; `bpf_mute` goes to the RX/TX path gating.

## Interface
- `STABLE_CYCLES`, 1024: consecutive cycles a new request must hold before switching starts; must be ≥1.
- `MUTE_LEAD`, 64: cycles of mute before the switch lines change; must be ≥1.
- `BREAK_CYCLES`, 4800: cycles the all-off break code is driven; must be ≥1.
- `SETTLE_CYCLES`, 48000: cycles after the new code before unmute; must be ≥1.
- `RESET_CODE`, 3'd6: switch code after reset (lowest band).
- `BREAK_CODE`, 3'd7: all-filters-off code driven during break.
- Parameter rule: every cycle count is at most 65535 (16-bit counter).
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `bpf_req` in 3: requested band code from the decoder. Valid codes are 0, 1, 2, 3 and 6.
- `hold` in 1: inhibits starting a new switch (high during TX).
- `bpf_out` out 3: registered drive to the filter switch lines.
- `bpf_mute` out 1: signal path mute, registered.
- `bpf_busy` out 1: high whenever the state is not IDLE.
- `bpf_done` out 1: one-cycle pulse when a switch sequence completes.

## Operation
- States: IDLE, QUALIFY, MUTE, BREAK, SETTLE. Registers: 16-bit `cnt` and 3-bit `cand`.
- Reset: `bpf_out`=RESET_CODE, `bpf_mute`=1, `bpf_busy`=1, `bpf_done`=0, state=SETTLE, `cnt`=0. Power-up therefore waits SETTLE_CYCLES, then unmutes.
- Invalid request codes (4, 5, 7) count as "no change".
- IDLE:
  - Leave when `bpf_req` is valid, `bpf_req` != `bpf_out`, and `hold`=0.
  - Then go to QUALIFY with `cand`=`bpf_req` and `cnt`=0.
- QUALIFY, checked in this priority order:
  1. `hold`=1, or `bpf_req` invalid, or `bpf_req`==`bpf_out`: return to IDLE.
  2. `bpf_req` != `cand`: set `cand`=`bpf_req` and `cnt`=0, stay in QUALIFY.
  3. Otherwise: when `cnt`==STABLE_CYCLES-1, go to MUTE with `cnt`=0 and `bpf_mute`=1; else increment `cnt`.
- MUTE:
  - Count MUTE_LEAD cycles.
  - Then go to BREAK with `bpf_out`=BREAK_CODE.
- BREAK:
  - Count BREAK_CYCLES cycles.
  - Then go to SETTLE with `bpf_out`=`cand`.
- SETTLE:
  - Count SETTLE_CYCLES cycles.
  - Then go to IDLE with `bpf_mute`=0 and a `bpf_done` pulse.
- From MUTE through SETTLE, `bpf_req` and `hold` are ignored. The sequence always completes. A new request is evaluated in the first IDLE cycle.
- `bpf_out` never changes directly from one valid code to another; BREAK_CODE is always driven in between.
- `bpf_out` only changes while `bpf_mute`=1.
- `reset` mid-sequence: immediate return to reset values, including `bpf_out`=RESET_CODE.

## Timing
- T0 is the rising edge at which IDLE first accepts a qualifying request.
- With the request stable and `hold`=0:
  - `bpf_mute` rises after edge T0+STABLE_CYCLES.
  - `bpf_out`=BREAK_CODE after edge T0+STABLE_CYCLES+MUTE_LEAD.
  - `bpf_out`=`cand` after edge T0+STABLE_CYCLES+MUTE_LEAD+BREAK_CYCLES.
  - `bpf_mute` falls and `bpf_done` pulses after edge T0+STABLE_CYCLES+MUTE_LEAD+BREAK_CYCLES+SETTLE_CYCLES. The pulse lasts one cycle.
- Any request glitch inside the qualify window restarts the full STABLE_CYCLES count.
- Back-to-back requests: the earliest re-entry to QUALIFY is one cycle after `bpf_done`.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
(All scenarios use STABLE_CYCLES=4, MUTE_LEAD=2, BREAK_CYCLES=3, SETTLE_CYCLES=5.)
- Reset release:
  - Stimulus: hold `bpf_req`=6.
  - Required: `bpf_out`=6 throughout; `bpf_mute`=1 for 5 cycles after reset release, then 0; one `bpf_done` pulse; `bpf_busy` falls with mute.
- Clean switch 6→0 with `hold`=0:
  - Required: mute rises 4 cycles after T0.
  - `bpf_out`=7 from T0+6, `bpf_out`=0 from T0+9, mute falls and `bpf_done` pulses at T0+14.
- Glitch:
  - Stimulus: `bpf_req` 6→2 for 2 cycles, then →3 and held.
  - Required: qualify restarts on the change to 3; mute rises 4 cycles after the 3 appears; the final `bpf_out` is 3, never 2.
- Hold and invalid codes:
  - Stimulus: `bpf_req`=1 with `hold`=1 for 50 cycles → required: no state change.
  - Stimulus: `hold` drops → required: switch to 1 on the nominal timeline.
  - Stimulus: `bpf_req`=5 → required: ignored.
- Mid-sequence events:
  - Stimulus: during BREAK, `bpf_req` changes to 2 and `hold`=1.
  - Required: the sequence still completes to the original code. The 2 is not qualified while `hold`=1; it qualifies after `hold`=0.
- Reset during SETTLE:
  - Required: the next cycle shows `bpf_out`=6, `bpf_mute`=1, state SETTLE with `cnt`=0.

Source files
------------

// File: rtl/bpf_switch_seq.sv
// Break-before-make sequencer for the band-pass filter switch lines.
// Qualifies a new band code, mutes, drives the all-off code, applies the new code, settles, unmutes.
module bpf_switch_seq #(
  parameter int         STABLE_CYCLES = 1024,
  parameter int         MUTE_LEAD     = 64,
  parameter int         BREAK_CYCLES  = 4800,
  parameter int         SETTLE_CYCLES = 48000,
  parameter logic [2:0] RESET_CODE    = 3'd6,
  parameter logic [2:0] BREAK_CODE    = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] bpf_req,
  input  logic       hold,
  output logic [2:0] bpf_out,
  output logic       bpf_mute,
  output logic       bpf_busy,
  output logic       bpf_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUALIFY = 3'd1,
    MUTE    = 3'd2,
    BREAK   = 3'd3,
    SETTLE  = 3'd4
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] MUTE_LAST   = 16'(MUTE_LEAD - 1);
  localparam logic [15:0] BREAK_LAST  = 16'(BREAK_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  // Only the codes the band decoder can legitimately produce may start a switch.
  function automatic logic code_valid(input logic [2:0] code);
    case (code)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd6: code_valid = 1'b1;
      default:                      code_valid = 1'b0;
    endcase
  endfunction

  state_t      state_r, state_next_s;
  logic [15:0] cnt_r, cnt_next_s;
  logic [2:0]  cand_r, cand_next_s;
  logic [2:0]  out_r, out_next_s;
  logic        mute_r, mute_next_s;
  logic        busy_r;
  logic        done_r, done_next_s;
  logic        req_ok_s;

  assign req_ok_s = code_valid(bpf_req) && (bpf_req != out_r);

  // Next-state and next-output logic of the switching sequence.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    cand_next_s  = cand_r;
    out_next_s   = out_r;
    mute_next_s  = mute_r;
    done_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_ok_s && !hold) begin
          state_next_s = QUALIFY;
          cand_next_s  = bpf_req;
          cnt_next_s   = 16'd0;
        end else begin
          state_next_s = IDLE;
        end
      end
      QUALIFY: begin
        if (hold || !req_ok_s) begin
          state_next_s = IDLE;
        end else if (bpf_req != cand_r) begin
          cand_next_s = bpf_req;
          cnt_next_s  = 16'd0;
        end else if (cnt_r == STABLE_LAST) begin
          state_next_s = MUTE;
          cnt_next_s   = 16'd0;
          mute_next_s  = 1'b1;
        end else begin
          cnt_next_s = cnt_r + 16'd1;
        end
      end
      MUTE: begin
        if (cnt_r == MUTE_LAST) begin
          state_next_s = BREAK;
          cnt_next_s   = 16'd0;
          out_next_s   = BREAK_CODE;
        end else begin
          cnt_next_s = cnt_r + 16'd1;
        end
      end
      BREAK: begin
        if (cnt_r == BREAK_LAST) begin
          state_next_s = SETTLE;
          cnt_next_s   = 16'd0;
          out_next_s   = cand_r;
        end else begin
          cnt_next_s = cnt_r + 16'd1;
        end
      end
      SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_next_s = IDLE;
          cnt_next_s   = 16'd0;
          mute_next_s  = 1'b0;
          done_next_s  = 1'b1;
        end else begin
          cnt_next_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_next_s = SETTLE;
        cnt_next_s   = 16'd0;
        out_next_s   = RESET_CODE;
        mute_next_s  = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs; reset lands in SETTLE so power-up waits before unmuting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SETTLE;
      cnt_r   <= 16'd0;
      cand_r  <= RESET_CODE;
      out_r   <= RESET_CODE;
      mute_r  <= 1'b1;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      cand_r  <= cand_next_s;
      out_r   <= out_next_s;
      mute_r  <= mute_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= done_next_s;
    end
  end

  assign bpf_out  = out_r;
  assign bpf_mute = mute_r;
  assign bpf_busy = busy_r;
  assign bpf_done = done_r;

endmodule

// File: tb/tb_bpf_switch_seq.sv
// Directed self-checking bench for bpf_switch_seq with short cycle counts (4/2/3/5).
module tb_bpf_switch_seq;

  logic       clk;
  logic       reset;
  logic [2:0] bpf_req;
  logic       hold;
  logic [2:0] bpf_out;
  logic       bpf_mute;
  logic       bpf_busy;
  logic       bpf_done;

  int n_cmp = 0;
  int n_bad = 0;

  bpf_switch_seq #(
    .STABLE_CYCLES(4),
    .MUTE_LEAD(2),
    .BREAK_CYCLES(3),
    .SETTLE_CYCLES(5),
    .RESET_CODE(3'd6),
    .BREAK_CODE(3'd7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bpf_req(bpf_req),
    .hold(hold),
    .bpf_out(bpf_out),
    .bpf_mute(bpf_mute),
    .bpf_busy(bpf_busy),
    .bpf_done(bpf_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {out,mute,busy,done} e edges after T0 for an undisturbed switch old->new.
  function automatic logic [5:0] exp_seq(input int e, input logic [2:0] old_c, input logic [2:0] new_c);
    logic [2:0] o;
    o = (e <= 5) ? old_c : (e <= 8) ? 3'd7 : new_c;
    return {o, (e >= 4 && e <= 13), (e <= 13), (e == 14)};
  endfunction

  task automatic test_reset();
    logic [5:0] want;
    reset = 1'b1; bpf_req = 3'd6; hold = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== 6'b110_110) begin
      n_bad++;
      $display("FAIL reset_state got=%b want=%b", {bpf_out, bpf_mute, bpf_busy, bpf_done}, 6'b110_110);
    end
    reset = 1'b0;
    for (int r = 1; r <= 7; r++) begin
      tick();
      want = (r <= 4) ? 6'b110_110 : (r == 5) ? 6'b110_001 : 6'b110_000;
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== want) begin
        n_bad++;
        $display("FAIL reset_release r=%0d got=%b want=%b", r, {bpf_out, bpf_mute, bpf_busy, bpf_done}, want);
      end
    end
  endtask

  task automatic test_clean_switch();
    bpf_req = 3'd0;
    for (int e = 0; e <= 15; e++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== exp_seq(e, 3'd6, 3'd0)) begin
        n_bad++;
        $display("FAIL clean e=%0d got=%b want=%b", e, {bpf_out, bpf_mute, bpf_busy, bpf_done}, exp_seq(e, 3'd6, 3'd0));
      end
    end
  endtask

  task automatic test_glitch();
    bpf_req = 3'd2;
    for (int g = 0; g < 2; g++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== 6'b000_010) begin
        n_bad++;
        $display("FAIL glitch_pre g=%0d got=%b want=%b", g, {bpf_out, bpf_mute, bpf_busy, bpf_done}, 6'b000_010);
      end
    end
    bpf_req = 3'd3;
    for (int e = 0; e <= 15; e++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== exp_seq(e, 3'd0, 3'd3)) begin
        n_bad++;
        $display("FAIL glitch e=%0d got=%b want=%b", e, {bpf_out, bpf_mute, bpf_busy, bpf_done}, exp_seq(e, 3'd0, 3'd3));
      end
    end
  endtask

  task automatic test_hold_invalid();
    bpf_req = 3'd1; hold = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== 6'b011_000) begin
        n_bad++;
        $display("FAIL hold c=%0d got=%b want=%b", c, {bpf_out, bpf_mute, bpf_busy, bpf_done}, 6'b011_000);
      end
    end
    hold = 1'b0;
    for (int e = 0; e <= 15; e++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== exp_seq(e, 3'd3, 3'd1)) begin
        n_bad++;
        $display("FAIL hold_release e=%0d got=%b want=%b", e, {bpf_out, bpf_mute, bpf_busy, bpf_done}, exp_seq(e, 3'd3, 3'd1));
      end
    end
    bpf_req = 3'd5;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== 6'b001_000) begin
        n_bad++;
        $display("FAIL invalid c=%0d got=%b want=%b", c, {bpf_out, bpf_mute, bpf_busy, bpf_done}, 6'b001_000);
      end
    end
  endtask

  task automatic test_mid_sequence();
    bpf_req = 3'd6;
    for (int e = 0; e <= 15; e++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== exp_seq(e, 3'd1, 3'd6)) begin
        n_bad++;
        $display("FAIL mid e=%0d got=%b want=%b", e, {bpf_out, bpf_mute, bpf_busy, bpf_done}, exp_seq(e, 3'd1, 3'd6));
      end
      if (e == 7) begin
        bpf_req = 3'd2;
        hold    = 1'b1;
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== 6'b110_000) begin
        n_bad++;
        $display("FAIL mid_hold c=%0d got=%b want=%b", c, {bpf_out, bpf_mute, bpf_busy, bpf_done}, 6'b110_000);
      end
    end
    hold = 1'b0;
    for (int e = 0; e <= 15; e++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== exp_seq(e, 3'd6, 3'd2)) begin
        n_bad++;
        $display("FAIL mid_after e=%0d got=%b want=%b", e, {bpf_out, bpf_mute, bpf_busy, bpf_done}, exp_seq(e, 3'd6, 3'd2));
      end
    end
  endtask

  task automatic test_back_to_back();
    bpf_req = 3'd0;
    for (int e = 0; e <= 14; e++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== exp_seq(e, 3'd2, 3'd0)) begin
        n_bad++;
        $display("FAIL b2b_first e=%0d got=%b want=%b", e, {bpf_out, bpf_mute, bpf_busy, bpf_done}, exp_seq(e, 3'd2, 3'd0));
      end
    end
    bpf_req = 3'd3;
    for (int e = 0; e <= 15; e++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== exp_seq(e, 3'd0, 3'd3)) begin
        n_bad++;
        $display("FAIL b2b_second e=%0d got=%b want=%b", e, {bpf_out, bpf_mute, bpf_busy, bpf_done}, exp_seq(e, 3'd0, 3'd3));
      end
    end
  endtask

  task automatic test_reset_settle();
    logic [5:0] want;
    bpf_req = 3'd6;
    for (int e = 0; e <= 11; e++) begin
      tick();
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== exp_seq(e, 3'd3, 3'd6)) begin
        n_bad++;
        $display("FAIL rs_pre e=%0d got=%b want=%b", e, {bpf_out, bpf_mute, bpf_busy, bpf_done}, exp_seq(e, 3'd3, 3'd6));
      end
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== 6'b110_110) begin
      n_bad++;
      $display("FAIL rs_state got=%b want=%b", {bpf_out, bpf_mute, bpf_busy, bpf_done}, 6'b110_110);
    end
    n_cmp++;
    if (dut.cnt_r !== 16'd0) begin
      n_bad++;
      $display("FAIL rs_cnt got=%0d want=0", dut.cnt_r);
    end
    reset = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      tick();
      want = (r <= 4) ? 6'b110_110 : (r == 5) ? 6'b110_001 : 6'b110_000;
      n_cmp++;
      if ({bpf_out, bpf_mute, bpf_busy, bpf_done} !== want) begin
        n_bad++;
        $display("FAIL rs_release r=%0d got=%b want=%b", r, {bpf_out, bpf_mute, bpf_busy, bpf_done}, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1; bpf_req = 3'd6; hold = 1'b0;
    test_reset();
    test_clean_switch();
    test_glitch();
    test_hold_invalid();
    test_mid_sequence();
    test_back_to_back();
    test_reset_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
